// File: rtl/bpm_link_tx.sv
// bpm_link_tx: BPM-side transmitter for the CCW/CW ring links.
// Each accepted FA strobe snapshots one X/Y/S sample. Every non-inhibited
// link then sends the packet {header, X, Y, S}, with tlast on S.
// Stream handshake: a word transfers on a cycle where tvalid & tready are
// both high. tvalid, once raised, stays high until the S word transfers.
// tdata/tlast hold while tvalid & !tready. tvalid never waits on tready.
module bpm_link_tx #(
    parameter logic [15:0] HEADER_MAGIC     = 16'hA5BC,
    parameter int          FOFB_INDEX_WIDTH = 9,
    parameter int          COUNTER_WIDTH    = 16
) (
    input  logic                        auroraUserClk,
    input  logic                        auroraUserResetN,
    input  logic                        auroraFAstrobe,
    input  logic [31:0]                 sampleX,
    input  logic [31:0]                 sampleY,
    input  logic [31:0]                 sampleS,
    input  logic [FOFB_INDEX_WIDTH-1:0] fofbIndex,
    input  logic                        ccwInhibit,
    input  logic                        cwInhibit,
    output logic [31:0]                 CCW_AXI_STREAM_TX_tdata,
    output logic                        CCW_AXI_STREAM_TX_tvalid,
    output logic                        CCW_AXI_STREAM_TX_tlast,
    input  logic                        CCW_AXI_STREAM_TX_tready,
    output logic [31:0]                 CW_AXI_STREAM_TX_tdata,
    output logic                        CW_AXI_STREAM_TX_tvalid,
    output logic                        CW_AXI_STREAM_TX_tlast,
    input  logic                        CW_AXI_STREAM_TX_tready,
    output logic                        busy,
    output logic [COUNTER_WIDTH-1:0]    ccwPacketCount,
    output logic [COUNTER_WIDTH-1:0]    cwPacketCount,
    output logic [COUNTER_WIDTH-1:0]    overrunCount,
    output logic [2:0]                  ccw_state,
    output logic [2:0]                  cw_state
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_X    = 3'd2;
    localparam logic [2:0] ST_Y    = 3'd3;
    localparam logic [2:0] ST_S    = 3'd4;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic [31:0]                 snap_x;
    logic [31:0]                 snap_y;
    logic [31:0]                 snap_s;
    logic [FOFB_INDEX_WIDTH-1:0] snap_index;
    logic [31:0]                 header_word;

    logic ccw_fire;
    logic cw_fire;
    logic ccw_done;
    logic cw_done;
    logic ccw_free;
    logic cw_free;
    logic accept;
    logic overrun_hit;

    // Word order within a packet; S wraps back to IDLE.
    function automatic logic [2:0] next_word(input logic [2:0] st);
        logic [2:0] nxt;
        nxt = ST_IDLE;
        case (st)
            ST_HDR:  nxt = ST_X;
            ST_X:    nxt = ST_Y;
            ST_Y:    nxt = ST_S;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    assign header_word = {HEADER_MAGIC, 16'(snap_index)};

    // A link is free if it is idle or its S word is transferring right now,
    // so a strobe arriving exactly at the end of a packet is still accepted.
    assign ccw_fire    = CCW_AXI_STREAM_TX_tvalid & CCW_AXI_STREAM_TX_tready;
    assign cw_fire     = CW_AXI_STREAM_TX_tvalid & CW_AXI_STREAM_TX_tready;
    assign ccw_done    = (ccw_state == ST_S) & CCW_AXI_STREAM_TX_tready;
    assign cw_done     = (cw_state == ST_S) & CW_AXI_STREAM_TX_tready;
    assign ccw_free    = (ccw_state == ST_IDLE) | ccw_done;
    assign cw_free     = (cw_state == ST_IDLE) | cw_done;
    assign accept      = auroraFAstrobe & ccw_free & cw_free;
    assign overrun_hit = auroraFAstrobe & ~accept;

    assign busy = (ccw_state != ST_IDLE) | (cw_state != ST_IDLE);

    // Snapshot of the sample taken on each accepted strobe.
    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            snap_x     <= '0;
            snap_y     <= '0;
            snap_s     <= '0;
            snap_index <= '0;
        end else if (accept) begin
            snap_x     <= sampleX;
            snap_y     <= sampleY;
            snap_s     <= sampleS;
            snap_index <= fofbIndex;
        end
    end

    // CCW link FSM: start on an accepted strobe, advance one word per handshake.
    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            ccw_state <= ST_IDLE;
        end else if (accept && !ccwInhibit) begin
            ccw_state <= ST_HDR;
        end else if (ccw_fire) begin
            ccw_state <= next_word(ccw_state);
        end
    end

    // CW link FSM: same as CCW and independent of it.
    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            cw_state <= ST_IDLE;
        end else if (accept && !cwInhibit) begin
            cw_state <= ST_HDR;
        end else if (cw_fire) begin
            cw_state <= next_word(cw_state);
        end
    end

    // Output word select. tvalid follows the state, so reset drops it at once.
    always_comb begin
        CCW_AXI_STREAM_TX_tdata = 32'd0;
        CW_AXI_STREAM_TX_tdata  = 32'd0;
        case (ccw_state)
            ST_HDR:  CCW_AXI_STREAM_TX_tdata = header_word;
            ST_X:    CCW_AXI_STREAM_TX_tdata = snap_x;
            ST_Y:    CCW_AXI_STREAM_TX_tdata = snap_y;
            ST_S:    CCW_AXI_STREAM_TX_tdata = snap_s;
            default: CCW_AXI_STREAM_TX_tdata = 32'd0;
        endcase
        case (cw_state)
            ST_HDR:  CW_AXI_STREAM_TX_tdata = header_word;
            ST_X:    CW_AXI_STREAM_TX_tdata = snap_x;
            ST_Y:    CW_AXI_STREAM_TX_tdata = snap_y;
            ST_S:    CW_AXI_STREAM_TX_tdata = snap_s;
            default: CW_AXI_STREAM_TX_tdata = 32'd0;
        endcase
    end

    assign CCW_AXI_STREAM_TX_tvalid = (ccw_state != ST_IDLE);
    assign CW_AXI_STREAM_TX_tvalid  = (cw_state != ST_IDLE);
    assign CCW_AXI_STREAM_TX_tlast  = (ccw_state == ST_S);
    assign CW_AXI_STREAM_TX_tlast   = (cw_state == ST_S);

    // Completed-packet counters, wrapping.
    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            ccwPacketCount <= '0;
            cwPacketCount  <= '0;
        end else begin
            if (ccw_done) ccwPacketCount <= ccwPacketCount + CNT_ONE;
            if (cw_done)  cwPacketCount  <= cwPacketCount + CNT_ONE;
        end
    end

    // Dropped-strobe counter, saturating at all-ones.
    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            overrunCount <= '0;
        end else if (overrun_hit && (overrunCount != '1)) begin
            overrunCount <= overrunCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_bpm_link_tx.sv
// tb_bpm_link_tx: directed, table-driven bench for bpm_link_tx.
// Each table row gives the inputs for one clock. It also gives the packet
// phase (0 idle, 1 hdr, 2 X, 3 Y, 4 S) that each link must present before
// that clock edge. The expected word comes from the segment's sample values.
module tb_bpm_link_tx;

    logic        clk;
    logic        rst_n;
    logic        strobe;
    logic [31:0] sample_x;
    logic [31:0] sample_y;
    logic [31:0] sample_s;
    logic [8:0]  fofb_index;
    logic        ccw_inh;
    logic        cw_inh;
    logic [31:0] ccw_tdata;
    logic        ccw_tvalid;
    logic        ccw_tlast;
    logic        ccw_tready;
    logic [31:0] cw_tdata;
    logic        cw_tvalid;
    logic        cw_tlast;
    logic        cw_tready;
    logic        busy;
    logic [15:0] ccw_count;
    logic [15:0] cw_count;
    logic [15:0] overrun_count;
    logic [2:0]  ccw_state;
    logic [2:0]  cw_state;

    int n_checks;
    int n_fail;

    bpm_link_tx dut (
        .auroraUserClk            (clk),
        .auroraUserResetN         (rst_n),
        .auroraFAstrobe           (strobe),
        .sampleX                  (sample_x),
        .sampleY                  (sample_y),
        .sampleS                  (sample_s),
        .fofbIndex                (fofb_index),
        .ccwInhibit               (ccw_inh),
        .cwInhibit                (cw_inh),
        .CCW_AXI_STREAM_TX_tdata  (ccw_tdata),
        .CCW_AXI_STREAM_TX_tvalid (ccw_tvalid),
        .CCW_AXI_STREAM_TX_tlast  (ccw_tlast),
        .CCW_AXI_STREAM_TX_tready (ccw_tready),
        .CW_AXI_STREAM_TX_tdata   (cw_tdata),
        .CW_AXI_STREAM_TX_tvalid  (cw_tvalid),
        .CW_AXI_STREAM_TX_tlast   (cw_tlast),
        .CW_AXI_STREAM_TX_tready  (cw_tready),
        .busy                     (busy),
        .ccwPacketCount           (ccw_count),
        .cwPacketCount            (cw_count),
        .overrunCount             (overrun_count),
        .ccw_state                (ccw_state),
        .cw_state                 (cw_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic stb;
        logic ccw_rdy;
        logic cw_rdy;
        logic ccw_in;
        logic cw_in;
        logic alt;      // drive inverted sample values on this strobe
        int   ccw_ph;
        int   cw_ph;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] seg_x;
    logic [31:0] seg_y;
    logic [31:0] seg_s;
    logic [8:0]  seg_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic stb, input logic cr, input logic wr,
                                input logic ci, input logic wi, input logic alt,
                                input int cp, input int wp);
        vec_t v;
        v.stb = stb; v.ccw_rdy = cr; v.cw_rdy = wr; v.ccw_in = ci; v.cw_in = wi;
        v.alt = alt; v.ccw_ph = cp; v.cw_ph = wp;
        tbl.push_back(v);
    endfunction

    function automatic logic [31:0] exp_word(input int ph);
        logic [31:0] w;
        case (ph)
            1:       w = {16'hA5BC, 7'd0, seg_idx};
            2:       w = seg_x;
            3:       w = seg_y;
            4:       w = seg_s;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    task automatic set_seg(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] s, input logic [8:0] idx);
        seg_x = x; seg_y = y; seg_s = s; seg_idx = idx;
    endtask

    // Driver + checker: apply every row, compare outputs before the edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            strobe     = tbl[i].stb;
            ccw_tready = tbl[i].ccw_rdy;
            cw_tready  = tbl[i].cw_rdy;
            ccw_inh    = tbl[i].ccw_in;
            cw_inh     = tbl[i].cw_in;
            if (tbl[i].stb && !tbl[i].alt) begin
                sample_x = seg_x; sample_y = seg_y; sample_s = seg_s; fofb_index = seg_idx;
            end else if (tbl[i].stb) begin
                sample_x = ~seg_x; sample_y = ~seg_y; sample_s = ~seg_s; fofb_index = ~seg_idx;
            end else begin
                sample_x = $urandom; sample_y = $urandom; sample_s = $urandom;
                fofb_index = 9'($urandom_range(0, 511));
            end
            #1;
            check($sformatf("%s[%0d] ccw_valid", tag, i), 32'(ccw_tvalid), 32'(tbl[i].ccw_ph != 0));
            check($sformatf("%s[%0d] ccw_data", tag, i), ccw_tdata, exp_word(tbl[i].ccw_ph));
            check($sformatf("%s[%0d] ccw_last", tag, i), 32'(ccw_tlast), 32'(tbl[i].ccw_ph == 4));
            check($sformatf("%s[%0d] cw_valid", tag, i), 32'(cw_tvalid), 32'(tbl[i].cw_ph != 0));
            check($sformatf("%s[%0d] cw_data", tag, i), cw_tdata, exp_word(tbl[i].cw_ph));
            check($sformatf("%s[%0d] cw_last", tag, i), 32'(cw_tlast), 32'(tbl[i].cw_ph == 4));
            check($sformatf("%s[%0d] busy", tag, i), 32'(busy),
                  32'((tbl[i].ccw_ph != 0) || (tbl[i].cw_ph != 0)));
        end
        @(negedge clk);
        strobe = 1'b0;
        tbl.delete();
    endtask

    task automatic check_counts(input string tag, input int ccw, input int cw, input int ovr);
        check({tag, " ccw_count"}, 32'(ccw_count), 32'(ccw));
        check({tag, " cw_count"}, 32'(cw_count), 32'(cw));
        check({tag, " overrun"}, 32'(overrun_count), 32'(ovr));
    endtask

    task automatic add_basic_packet();
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 2, 2);
        add(0, 1, 1, 0, 0, 0, 3, 3);
        add(0, 1, 1, 0, 0, 0, 4, 4);
        add(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; strobe = 1'b0; ccw_inh = 1'b0; cw_inh = 1'b0;
        ccw_tready = 1'b1; cw_tready = 1'b1;
        sample_x = '0; sample_y = '0; sample_s = '0; fofb_index = '0;
        set_seg(32'h0000_1234, 32'hFFFF_FF00, 32'h0000_0ABC, 9'd37);
        repeat (3) @(negedge clk);
        // Reset state
        check("rst ccw_valid", 32'(ccw_tvalid), 32'd0);
        check("rst cw_valid", 32'(cw_tvalid), 32'd0);
        check("rst ccw_data", ccw_tdata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ccw_state", 32'(ccw_state), 32'd0);
        check_counts("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Basic packet on both links.
        add_basic_packet();
        run_table("basic");
        check("basic hdr word", exp_word(1), 32'hA5BC_0025);
        check_counts("basic", 1, 1, 0);

        // CCW back-pressure 1,0,0,1,...; CW runs unaffected.
        set_seg(32'hDEAD_BEEF, 32'h0123_4567, 32'h8000_0001, 9'd511);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 2, 2);
        add(0, 0, 1, 0, 0, 0, 2, 3);
        add(0, 1, 1, 0, 0, 0, 2, 4);
        add(0, 1, 1, 0, 0, 0, 3, 0);
        add(0, 1, 1, 0, 0, 0, 4, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        run_table("stall");
        check_counts("stall", 2, 2, 0);

        // CCW inhibited at strobe, released mid-session; then both inhibited.
        set_seg(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 9'd0);
        add(1, 1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 2);
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 0, 0, 0, 0, 4);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        run_table("inhibit");
        check_counts("inhibit", 2, 3, 0);

        // Overrun: CW stalled on header, second strobe (different data) dropped.
        set_seg(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 9'd300);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 2, 1);
        add(0, 1, 0, 0, 0, 0, 3, 1);
        add(0, 1, 0, 0, 0, 0, 4, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 2);
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 0, 0, 0, 0, 4);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        run_table("overrun");
        check_counts("overrun", 3, 4, 1);

        // Strobe coinciding with the S handshake on both links is accepted.
        set_seg(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 9'd1);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 2, 2);
        add(0, 1, 1, 0, 0, 0, 3, 3);
        add(1, 1, 1, 0, 0, 0, 4, 4);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 2, 2);
        add(0, 1, 1, 0, 0, 0, 3, 3);
        add(0, 1, 1, 0, 0, 0, 4, 4);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        run_table("edge");
        check_counts("edge", 5, 6, 1);

        // Overrun saturation: CW stalled, strobe every cycle.
        set_seg(32'h0BAD_F00D, 32'h0000_0042, 32'h0000_0043, 9'd99);
        @(negedge clk);
        sample_x = seg_x; sample_y = seg_y; sample_s = seg_s; fofb_index = seg_idx;
        strobe = 1'b1; ccw_tready = 1'b1; cw_tready = 1'b0;
        for (int i = 0; i < 65540; i++) @(negedge clk);
        #1;
        check("sat overrun", 32'(overrun_count), 32'h0000_FFFF);
        check("sat cw_data", cw_tdata, 32'hA5BC_0063);
        @(negedge clk);
        strobe = 1'b0; cw_tready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_counts("sat", 6, 7, 32'hFFFF);

        // Reset during the X word.
        set_seg(32'h0000_1234, 32'hFFFF_FF00, 32'h0000_0ABC, 9'd37);
        @(negedge clk);
        sample_x = seg_x; sample_y = seg_y; sample_s = seg_s; fofb_index = seg_idx;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        #1;
        check("mid ccw_data X", ccw_tdata, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        check("rstmid ccw_valid", 32'(ccw_tvalid), 32'd0);
        check("rstmid cw_valid", 32'(cw_tvalid), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstrel busy", 32'(busy), 32'd0);
        check_counts("rstrel", 0, 0, 0);
        add_basic_packet();
        run_table("post_rst");
        check_counts("post_rst", 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
